// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared types and rule constants for the Game of Life engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // B3/S23 rule thresholds
    localparam logic [3:0] BIRTH_N     = 4'd3;
    localparam logic [3:0] SURVIVE_MIN = 4'd2;
    localparam logic [3:0] SURVIVE_MAX = 4'd3;

    // Number of set bits in an 8-neighbour vector
    function automatic logic [3:0] count8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_next_state.sv
`default_nettype none
// ============================================================================
//  Module      : life_next_state
//  Description : Combinational B3/S23 generation step over a flat cell array
//                (bit r*COLS+c = row r, column c) plus a "no change" flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_next_state
    import life_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int WRAP = 1
) (
    input  logic [ROWS*COLS-1:0] cells_i,
    output logic [ROWS*COLS-1:0] next_o,
    output logic                 stable_o
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] w_nb;
            logic [3:0] w_cnt;

            // Neighbour k: k=0..2 row above, k=3/4 same row, k=5..7 row below.
            // Offsets and wrapped coordinates are resolved at elaboration so
            // every neighbour tap is a fixed wire.
            for (genvar k = 0; k < 8; k++) begin : g_nb
                localparam int DR     = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int DC     = (k < 3) ? (k - 1) :
                                        ((k == 3) ? -1 : ((k == 4) ? 1 : (k - 6)));
                localparam int RR     = r + DR;
                localparam int CC     = c + DC;
                localparam bit INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                localparam int RWR    = (RR + ROWS) % ROWS;
                localparam int CWR    = (CC + COLS) % COLS;
                if ((WRAP != 0) || INSIDE) begin : g_live
                    assign w_nb[k] = cells_i[RWR*COLS + CWR];
                end else begin : g_dead
                    assign w_nb[k] = 1'b0;
                end
            end

            assign w_cnt = count8(w_nb);
            assign next_o[r*COLS + c] = (w_cnt == BIRTH_N) ||
                                        (cells_i[r*COLS + c] &&
                                         (w_cnt >= SURVIVE_MIN) && (w_cnt <= SURVIVE_MAX));
        end
    end

    assign stable_o = (next_o == cells_i);

endmodule
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
//  Module      : life_engine
//  Description : Game of Life engine: cell array, pause/run/halt control,
//                row-wise loading, generation timer and LED matrix scan.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int GEN_TICKS  = 12_000_000,
    parameter int SCAN_TICKS = 1_500,
    parameter int WRAP       = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          step,
    input  logic                          clear,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [COLS-1:0]               load_row,
    output logic [COLS-1:0]               rows_out,
    output logic [ROWS-1:0]               columns_out,
    output logic [15:0]                   generation,
    output logic [$clog2(ROWS*COLS+1)-1:0] population,
    output logic                          stable,
    output logic                          halted
);

    localparam int CELLS = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GW    = $clog2(GEN_TICKS);
    localparam int SW    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int PW    = $clog2(ROWS*COLS+1);

    localparam logic [GW-1:0] GEN_LAST  = GW'(GEN_TICKS - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    state_t             state_q, state_d;
    logic [CELLS-1:0]   cells_q, cells_d;
    logic [15:0]        gen_q, gen_d;
    logic [RW-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]      gtimer_q, gtimer_d;
    logic [SW-1:0]      stimer_q, stimer_d;
    logic [RW-1:0]      sidx_q, sidx_d;
    logic [COLS-1:0]    rows_q, rows_d;
    logic [ROWS-1:0]    cols_q, cols_d;
    logic [PW-1:0]      pop_q, pop_d;

    logic [CELLS-1:0]   w_next;
    logic               w_stable;
    logic               w_commit;
    logic               w_load_fire;

    life_next_state #(
        .ROWS (ROWS),
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_next (
        .cells_i  (cells_q),
        .next_o   (w_next),
        .stable_o (w_stable)
    );

    assign load_ready  = (state_q == S_PAUSE);
    assign w_load_fire = load_valid && load_ready;

    // Next state, generation timer, commit/load/clear of the array and counters
    always_comb begin
        state_d  = state_q;
        cells_d  = cells_q;
        gen_d    = gen_q;
        ptr_d    = ptr_q;
        gtimer_d = gtimer_q;
        w_commit = 1'b0;

        case (state_q)
            S_PAUSE: begin
                gtimer_d = '0;
                if (run) begin
                    state_d = S_RUN;
                end
                // a load in the same cycle takes precedence over step
                if (step && !w_load_fire) begin
                    w_commit = 1'b1;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_d  = S_PAUSE;
                    gtimer_d = '0;
                end else if (gtimer_q == GEN_LAST) begin
                    w_commit = 1'b1;
                    gtimer_d = '0;
                    if (w_stable) begin
                        state_d = S_HALT;
                    end
                end else begin
                    gtimer_d = gtimer_q + 1'b1;
                end
            end
            S_HALT: begin
                gtimer_d = '0;
                if (!run) begin
                    state_d = S_PAUSE;
                end
            end
            default: begin
                state_d  = S_PAUSE;
                gtimer_d = '0;
            end
        endcase

        if (w_commit) begin
            cells_d = w_next;
            gen_d   = gen_q + 16'd1;
        end

        if (w_load_fire) begin
            for (int r = 0; r < ROWS; r++) begin
                if (ptr_q == RW'(r)) begin
                    cells_d[r*COLS +: COLS] = load_row;
                end
            end
            ptr_d = (ptr_q == ROW_LAST) ? '0 : ptr_q + 1'b1;
        end

        if (clear) begin
            state_d  = S_PAUSE;
            cells_d  = '0;
            gen_d    = '0;
            ptr_d    = '0;
            gtimer_d = '0;
        end
    end

    // Live-cell count of the committed array
    always_comb begin
        pop_d = '0;
        for (int i = 0; i < CELLS; i++) begin
            pop_d = pop_d + {{(PW-1){1'b0}}, cells_q[i]};
        end
    end

    // Scan divider; on each row change latch the new row select and its pattern
    always_comb begin
        stimer_d = stimer_q + 1'b1;
        sidx_d   = sidx_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        if (stimer_q == SCAN_LAST) begin
            stimer_d = '0;
            sidx_d   = (sidx_q == ROW_LAST) ? '0 : sidx_q + 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                cols_d[r] = (sidx_d == RW'(r));
                if (sidx_d == RW'(r)) begin
                    rows_d = ~cells_q[r*COLS +: COLS];
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PAUSE;
        end else begin
            state_q <= state_d;
        end
    end

    // Array, counters, timers and population register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cells_q  <= '0;
            gen_q    <= '0;
            ptr_q    <= '0;
            gtimer_q <= '0;
            pop_q    <= '0;
        end else begin
            cells_q  <= cells_d;
            gen_q    <= gen_d;
            ptr_q    <= ptr_d;
            gtimer_q <= gtimer_d;
            pop_q    <= pop_d;
        end
    end

    // Display scan registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stimer_q <= '0;
            sidx_q   <= '0;
            rows_q   <= '1;
            cols_q   <= {{(ROWS-1){1'b0}}, 1'b1};
        end else begin
            stimer_q <= stimer_d;
            sidx_q   <= sidx_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
        end
    end

    assign rows_out    = rows_q;
    assign columns_out = cols_q;
    assign generation  = gen_q;
    assign population  = pop_q;
    assign stable      = w_stable;
    assign halted      = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: doc/life_engine.md
# life_engine

Parametrised Game of Life engine for the LED-matrix life display: holds a ROWS×COLS cell array, advances it by one generation on a programmable timer or on a single-step request, and scans the array onto a row/column multiplexed LED matrix. It adds row-wise pattern loading, pause/run/auto-halt control, toroidal or dead-edge boundaries, and generation/population status.

## Interface

- ROWS, default 8: cell rows; also the number of scan columns driven.
- COLS, default 8: cells per row.
- GEN_TICKS, default 12_000_000: clk cycles per generation in RUN; must be ≥2.
- SCAN_TICKS, default 1_500: clk cycles each display row is lit; must be ≥1.
- WRAP, default 1: 1 = toroidal neighbours, 0 = cells outside the array are dead.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  level; 1 requests free-running generations.
- step  in  1  one-cycle pulse; advances one generation while paused.
- clear  in  1  one-cycle pulse; zeroes the array and counters.
- load_valid  in  1  load_row holds a row to write.
- load_ready  out  1  engine accepts load writes (PAUSE only).
- load_row  in  COLS  row pattern; bit c = column c.
- rows_out  out  COLS  active-low LED pattern of the scanned row.
- columns_out  out  ROWS  one-hot active-high select of the scanned row.
- generation  out  16  generations committed since reset/clear.
- population  out  $clog2(ROWS*COLS+1)  live cells in the current array.
- stable  out  1  next generation equals current array.
- halted  out  1  state is HALT.

## Operation

- Rule B3/S23: dead cell with exactly 3 live neighbours is born; live cell with 2 or 3 survives; otherwise dead. Neighbours per WRAP.
- FSM states S_PAUSE, S_RUN, S_HALT; reset state S_PAUSE.
  - S_PAUSE → S_RUN when run=1. S_RUN → S_PAUSE when run=0 (gen timer cleared). S_RUN → S_HALT on a commit where stable=1. S_HALT → S_PAUSE when run=0.
- Commit = cells ← next cells, generation += 1 (wraps 0xFFFF→0).
  - S_RUN: gen timer counts 0..GEN_TICKS-1; commit in the cycle it equals GEN_TICKS-1, then restarts at 0. Timer held at 0 outside S_RUN.
  - S_PAUSE: step=1 commits once. step ignored in S_RUN and S_HALT.
- Load: load_ready=1 iff state is S_PAUSE. On load_valid & load_ready, row[load_ptr] ← load_row, load_ptr increments, wraps ROWS-1→0. load_ptr reset to 0 by reset and clear. Load and step in the same cycle: load wins, step dropped.
- clear: cells, generation, load_ptr, gen timer ← 0; state ← S_PAUSE. Overrides commit, load and step in the same cycle.
- Display scan runs in every state: scan timer divides by SCAN_TICKS; scan row index 0..ROWS-1 wraps. columns_out = one-hot(index); rows_out = ~cells[index].
- Reset values: cells 0, generation 0, population 0, stable 1 (empty array is stable), halted 0, load_ready 1, columns_out = one-hot row 0, rows_out all ones.

## Timing

- All outputs registered except load_ready, stable and halted (decoded from state/array).
- Commit, load write and clear take effect at the clock edge ending the requesting cycle; new array visible the next cycle.
- population lags the array by one cycle.
- rows_out/columns_out change together, once per SCAN_TICKS cycles; a commit mid-row updates rows_out at the next scan-register update.
- rst_n deassertion mid-operation: all state returns to reset values asynchronously; no partial commit.

## Structure

- Package life_pkg: state_t enum {S_PAUSE, S_RUN, S_HALT}; rule constants BIRTH_N=3, SURVIVE_MIN=2, SURVIVE_MAX=3.
- Sub-module life_next_state (combinational, params ROWS, COLS, WRAP): cells in → next cells out and stable. Engine holds FSM, timers, load path, counters and scan.

## Test plan

ROWS=COLS=8, GEN_TICKS=4, SCAN_TICKS=2 unless noted.
- Reset → rows_out=8'hFF, columns_out=8'h01, generation=0, population=0, load_ready=1, halted=0.
- Load rows 0..7 with only row3=8'b00011100; step → rows 2,3,4 = 8'b00001000, population=3, generation=1; step → row3=8'b00011100, generation=2.
- Load 2×2 block rows 3–4 cols 3–4, run=1 → one commit after 4 cycles, generation=1, halted=1; 20 more cycles, generation stays 1; run=0 → S_PAUSE, load_ready=1.
- Row0=8'b10000011, WRAP=1, step → column 0 set in rows 7,0,1 only; same with WRAP=0 → population=0.
- Run a blinker, assert clear in the commit cycle → array 0, generation=0, state S_PAUSE.
- Load row1=8'hA5 → columns_out sequence 01,02,…,80,01 every 2 cycles; rows_out=8'h5A while columns_out=8'h02, 8'hFF otherwise.
